// File: rtl/ariane_pkg.sv
// Shared core types consumed by the fetch-entry queue and the decode stage.
package ariane_pkg;
    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        cf_t                     cf;
        logic [riscv::VLEN-1:0]  predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0]  cause;
        logic [riscv::VLEN-1:0]  tval;
        logic                    valid;
    } frontend_exception_t;

    typedef struct packed {
        logic [riscv::VLEN-1:0]  address;
        logic [31:0]             instruction;
        branchpredict_sbe_t      branch_predict;
        frontend_exception_t     ex;
    } fetch_entry_t;

    // A 16-bit parcel starts a compressed instruction unless its low bits are 2'b11.
    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/fetch_entry_queue_pkg.sv
// Local constants and helpers for the fetch-entry queue.
package fetch_entry_queue_pkg;
    import ariane_pkg::*;

    localparam logic [riscv::VLEN-1:0] PARCEL_BYTES = riscv::VLEN'(2);

    // Plain fetch entry: no prediction, no exception.
    function automatic fetch_entry_t make_entry(input logic [riscv::VLEN-1:0] addr,
                                                input logic [31:0]            instr);
        fetch_entry_t e;
        e                               = '0;
        e.address                       = addr;
        e.instruction                   = instr;
        e.branch_predict.cf             = NoCF;
        e.branch_predict.predict_address = '0;
        return e;
    endfunction
endpackage

// File: rtl/riscv.sv
// Minimal RISC-V architectural widths shared by the fetch path.
package riscv;
    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;
endpackage

// File: rtl/fetch_entry_queue_if.sv
// Fetch-block input channel and fetch-entry output channel of the queue.
interface fetch_entry_queue_if;
    // Both channels: a transfer happens on a rising clock edge where valid & ready
    // are high; the sender holds its payload stable while valid is high and ready low,
    // and ready may depend combinationally on queue state but never on valid.
    logic                             fetch_valid_i;
    logic                             fetch_ready_o;
    logic [riscv::VLEN-1:0]           fetch_addr_i;
    logic [31:0]                      fetch_data_i;
    logic                             fetch_start_half_i;
    ariane_pkg::frontend_exception_t  fetch_ex_i;
    ariane_pkg::fetch_entry_t         fetch_entry_o;
    logic                             fetch_entry_valid_o;
    logic                             fetch_entry_ready_i;

    modport slave (
        input  fetch_valid_i, fetch_addr_i, fetch_data_i, fetch_start_half_i,
               fetch_ex_i, fetch_entry_ready_i,
        output fetch_ready_o, fetch_entry_o, fetch_entry_valid_o
    );

    modport master (
        output fetch_valid_i, fetch_addr_i, fetch_data_i, fetch_start_half_i,
               fetch_ex_i, fetch_entry_ready_i,
        input  fetch_ready_o, fetch_entry_o, fetch_entry_valid_o
    );
endinterface

// File: rtl/fetch_entry_queue.sv
// Splits aligned 32-bit fetch blocks into 16/32-bit fetch entries and buffers them
// for decode in a dual-write-port FIFO.
module fetch_entry_queue
    import ariane_pkg::*;
    import fetch_entry_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    fetch_entry_queue_if.slave fe
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic                    pending_q, pending_d;
    logic [15:0]             pending_lo_q, pending_lo_d;
    logic [riscv::VLEN-1:0]  pending_addr_q, pending_addr_d;
    logic                    halted_q, halted_d;

    logic [AW-1:0]           wptr_q, rptr_q, wptr_p1;
    logic [CW-1:0]           count_q;
    fetch_entry_t            mem_q [DEPTH];

    logic                    ready, accept, empty, pop;
    logic                    half0_used, half1_used;
    logic [riscv::VLEN-1:0]  addr_hi;
    fetch_entry_t            push0, push1, hi_entry;
    logic [1:0]              n_push;

    // Two free slots are always required so any block can be taken in one cycle.
    assign ready  = !flush_i && !halted_q && (count_q <= CW'(DEPTH - 2));
    assign accept = fe.fetch_valid_i && ready;
    assign empty  = (count_q == '0);
    assign pop    = !empty && fe.fetch_entry_ready_i && !flush_i;

    assign fe.fetch_ready_o       = ready;
    assign fe.fetch_entry_valid_o = !empty;
    assign fe.fetch_entry_o       = mem_q[rptr_q];

    assign addr_hi  = fe.fetch_addr_i + PARCEL_BYTES;
    assign wptr_p1  = wptr_q + AW'(1);
    assign hi_entry = make_entry(addr_hi, {16'h0000, fe.fetch_data_i[31:16]});

    always_comb begin
        push0          = make_entry('0, '0);
        push1          = make_entry('0, '0);
        n_push         = 2'd0;
        pending_d      = pending_q;
        pending_lo_d   = pending_lo_q;
        pending_addr_d = pending_addr_q;
        halted_d       = halted_q;
        half0_used     = 1'b0;
        half1_used     = 1'b0;

        if (accept) begin
            if (fe.fetch_ex_i.valid) begin
                // A straddling instruction faults on the page of its second half.
                push0 = make_entry(pending_q ? pending_addr_q
                                   : (fe.fetch_start_half_i ? addr_hi : fe.fetch_addr_i),
                                   32'h0);
                push0.ex = fe.fetch_ex_i;
                if (pending_q) begin
                    push0.ex.tval = fe.fetch_addr_i;
                end
                n_push    = 2'd1;
                pending_d = 1'b0;
                halted_d  = 1'b1;
            end else begin
                if (pending_q) begin
                    push0      = make_entry(pending_addr_q, {fe.fetch_data_i[15:0], pending_lo_q});
                    n_push     = 2'd1;
                    pending_d  = 1'b0;
                    half0_used = 1'b1;
                end else if (fe.fetch_start_half_i) begin
                    half0_used = 1'b1;
                end

                if (!half0_used) begin
                    if (is_compressed(fe.fetch_data_i[15:0])) begin
                        push0 = make_entry(fe.fetch_addr_i, {16'h0000, fe.fetch_data_i[15:0]});
                    end else begin
                        push0      = make_entry(fe.fetch_addr_i, fe.fetch_data_i);
                        half1_used = 1'b1;
                    end
                    n_push = 2'd1;
                end

                if (!half1_used) begin
                    if (is_compressed(fe.fetch_data_i[31:16])) begin
                        if (n_push == 2'd0) begin
                            push0 = hi_entry;
                        end else begin
                            push1 = hi_entry;
                        end
                        n_push = n_push + 2'd1;
                    end else begin
                        pending_d      = 1'b1;
                        pending_lo_d   = fe.fetch_data_i[31:16];
                        pending_addr_d = addr_hi;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q      <= 1'b0;
            pending_lo_q   <= '0;
            pending_addr_q <= '0;
            halted_q       <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
        end else if (flush_i) begin
            pending_q <= 1'b0;
            halted_q  <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            pending_q      <= pending_d;
            pending_lo_q   <= pending_lo_d;
            pending_addr_q <= pending_addr_d;
            halted_q       <= halted_d;
            wptr_q         <= wptr_q + AW'(n_push);
            rptr_q         <= rptr_q + AW'(pop);
            count_q        <= count_q + CW'(n_push) - CW'(pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (n_push != 2'd0) begin
            mem_q[wptr_q] <= push0;
        end
        if (n_push == 2'd2) begin
            mem_q[wptr_p1] <= push1;
        end
    end

    a_no_pending_with_start_half: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(accept && pending_q && fe.fetch_start_half_i)
    );
endmodule

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Producer end of the fetch-entry valid/ready interface that the decode stage consumes.
- Accepts 32-bit aligned instruction-fetch blocks from the frontend and splits each into 16/32-bit instructions, carrying unaligned 32-bit instructions across block boundaries.
- Buffers the resulting ariane_pkg::fetch_entry_t records in a small FIFO and presents them to decode.
- Sits between the frontend fetch datapath and id_stage.

Parameters:
- DEPTH, 4, number of fetch entries buffered; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered and pending state
- fetch_valid_i  in  1  fetch block valid
- fetch_ready_o  out  1  block accepted when valid & ready
- fetch_addr_i  in  riscv::VLEN  block address, [1:0] = 0
- fetch_data_i  in  32  block data; half0 = [15:0], half1 = [31:16]
- fetch_start_half_i  in  1  first useful parcel is half1 (jump target at addr+2)
- fetch_ex_i  in  ariane_pkg::frontend_exception_t  fetch exception for block
- fetch_entry_o  out  ariane_pkg::fetch_entry_t  head entry to decode
- fetch_entry_valid_o  out  1  head entry valid
- fetch_entry_ready_i  in  1  decode pops head when valid & ready

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i.
  - FIFO empty, pending_q = 0, halted_q = 0.
  - fetch_entry_valid_o = 0, fetch_ready_o = 1.
- Ready rule (combinational):
  - fetch_ready_o = !flush_i & !halted_q & (DEPTH - count_q >= 2).
  - count_q is the registered occupancy; a same-cycle pop does not free space.
- Acceptance: a block is consumed in a single cycle and pushes 0, 1 or 2 entries. Entries are visible at the FIFO head no earlier than the next cycle (latency 1).
- Parcel scan, in order:
  - Step a, pending_q set: emit a 32-bit entry with address pending_addr_q and instruction {data[15:0], pending_lo_q}. Clear pending_q. Half0 is consumed.
  - Step b, half0 not yet consumed and start_half = 0:
    - data[1:0] != 2'b11: emit a compressed entry at addr; instruction = zero-extended parcel.
    - Otherwise: emit a 32-bit entry at addr with instruction = data[31:0]. Half1 is consumed.
  - Step c, half1 not yet consumed:
    - data[17:16] != 2'b11: emit a compressed entry at addr+2.
    - Otherwise: set pending_q, pending_lo_q = data[31:16], pending_addr_q = addr+2. Emit nothing for this half.
  - pending_q together with start_half = 1 is illegal. The block must carry an assertion for it; it ignores start_half in that case.
  - Entry order in the FIFO follows address order.
- Entry fields:
  - instruction as above; address as above.
  - branch_predict.cf = ariane_pkg::NoCF, predict_address = 0.
  - ex = 0 for normal entries.
- Exception block (fetch_ex_i.valid when accepted):
  - Push exactly one entry: instruction = 0, ex = fetch_ex_i.
  - Entry address:
    - pending_q set: pending_addr_q; ex.tval = fetch_addr_i, so the straddling instruction faults on its second page.
    - Otherwise: fetch_addr_i + 2*fetch_start_half_i.
  - Clear pending_q and set halted_q. fetch_ready_o stays 0 until flush.
  - Already-buffered entries still drain to decode.
- Output:
  - fetch_entry_o = FIFO head; fetch_entry_valid_o = !empty.
  - Pop on valid & fetch_entry_ready_i.
  - Push and pop in the same cycle are both honoured; count is unchanged by a net push/pop of 1/1.
- Flush (flush_i = 1):
  - Next cycle: FIFO empty, pending_q = 0, halted_q = 0.
  - An input block is not accepted in the flush cycle (ready forced 0).
  - A pop in the flush cycle is irrelevant.
- Full: with count_q >= DEPTH-1, ready = 0 and the frontend holds the block stable.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Use common_cells fifo_v3 (DATA_T = ariane_pkg::fetch_entry_t, DEPTH) as the single sub-module. Its 2-push capability is built as two sequential-slot writes in a local wrapper, or the FIFO is written inline with dual write ports. Inline is preferred: one module, about 250 lines.
- Shared package ariane_pkg already provides fetch_entry_t, frontend_exception_t and NoCF.
- Add ariane_pkg::is_compressed(parcel) helper function: parcel[1:0] != 2'b11.

Test Plan:
- Reset, idle: ready = 1, valid = 0. Block addr 0x80000000, data 0x00138513 (addi, 32-bit) -> next cycle one entry at 0x80000000, instr 0x00138513.
- Two compressed: data 0x40014501 -> entries 0x80000000/0x4501 then 0x80000002/0x4001, in that order.
- Straddle: block @0x1000 data 0x0513_4501 -> entry 0x1000/0x4501, pending. Block @0x1004 data 0x4505_0013 -> entry 0x1002/0x00130513, then 0x1006/0x4505.
- Start half: addr 0x2000, start_half = 1, data 0x4581_xxxx -> single entry 0x2002/0x4581.
- Exception with pending: pending at 0x1ffe, then block @0x2000 with ex.valid, cause 12 -> entry address 0x1ffe, tval 0x2000. fetch_ready_o = 0 until flush_i, then 1 with FIFO empty.
- Backpressure/full, DEPTH = 4: fetch_entry_ready_i = 0, push 3 entries -> ready = 0. Single pop -> ready returns next cycle. Order preserved across pointer wrap.
